// File: rtl/ssd_scan_ctrl_pkg.sv
// Shared types and the hex-to-seven-segment decode for the display scan controller.
package ssd_pkg;

  typedef enum logic {DEAD, DRIVE} scan_state_t;

  // Segment order {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    return SEG_TABLE[value];
  endfunction

endpackage

// File: rtl/ssd_scan_ctrl_slot_timer.sv
// Per-digit slot timing: a DEAD gap of DEAD_CYCLES followed by a DRIVE window,
// with a one-cycle slot_end pulse on the last DRIVE cycle.
module ssd_slot_timer
  import ssd_pkg::*;
#(
  parameter int PERIOD      = 10,
  parameter int DEAD_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  output logic drive_active,
  output logic slot_end
);

  localparam int CNT_W = $clog2(PERIOD + 1);
  localparam logic [CNT_W-1:0] DEAD_LAST  = CNT_W'((DEAD_CYCLES > 0) ? DEAD_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(PERIOD - DEAD_CYCLES - 1);

  scan_state_t      state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DEAD;
      cnt   <= '0;
    end else begin
      case (state)
        DEAD: begin
          if (cnt == DEAD_LAST) begin
            state <= DRIVE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          if (cnt == DRIVE_LAST) begin
            state <= DEAD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign drive_active = (state == DRIVE);
  assign slot_end     = (state == DRIVE) && (cnt == DRIVE_LAST);

endmodule

// File: rtl/ssd_scan_ctrl.sv
// N-digit multiplexed seven-segment controller with right-shifting key entry buffer.
// Optional cursor blink on digit 0 enabled by defining SSD_CURSOR_BLINK_EN.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS  = 2,
  parameter int CLK_FREQ    = 125_000_000,
  parameter int REFRESH_HZ  = 1000,
  parameter int DEAD_CYCLES = 16,
  parameter int BLINK_DIV   = 62_500_000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            key_valid,
  input  logic [3:0]                      key_code,
  input  logic                            clear,
  output logic [6:0]                      seg,
  output logic [NUM_DIGITS-1:0]           dig_en,
  output logic [4*NUM_DIGITS-1:0]         disp_value,
  output logic [$clog2(NUM_DIGITS+1)-1:0] digit_count
);

  localparam int PERIOD = CLK_FREQ / (REFRESH_HZ * NUM_DIGITS);
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CNT_W  = $clog2(NUM_DIGITS + 1);

  if (PERIOD <= DEAD_CYCLES || BLINK_DIV < 1 || NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_cfg
    $error("ssd_scan_ctrl: slot PERIOD must exceed DEAD_CYCLES, BLINK_DIV >= 1, NUM_DIGITS in 1..8");
  end

  logic [NUM_DIGITS-1:0][3:0] digits;
  logic [NUM_DIGITS-1:0]      valid_mask;
  logic [IDX_W-1:0]           index;
  logic                       drive_active;
  logic                       slot_end;
  logic                       cursor_blank;

  ssd_slot_timer #(
    .PERIOD      (PERIOD),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_timer (
    .clk          (clk),
    .rst          (rst),
    .drive_active (drive_active),
    .slot_end     (slot_end)
  );

  // Entry buffer: clear has priority over a simultaneous key.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      digits      <= '0;
      valid_mask  <= '0;
      digit_count <= '0;
    end else if (key_valid) begin
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        digits[i]     <= digits[i-1];
        valid_mask[i] <= valid_mask[i-1];
      end
      digits[0]     <= key_code;
      valid_mask[0] <= 1'b1;
      if (digit_count != CNT_W'(NUM_DIGITS))
        digit_count <= digit_count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      index <= '0;
    else if (slot_end)
      index <= (index == IDX_W'(NUM_DIGITS - 1)) ? '0 : index + 1'b1;
  end

`ifdef SSD_CURSOR_BLINK_EN
  localparam int BW = $clog2(BLINK_DIV + 1);
  logic [BW-1:0] blink_cnt;
  logic          blink_on;

  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt <= '0;
      blink_on  <= ~blink_on;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Cursor only blinks on a partially filled buffer.
  assign cursor_blank = !blink_on && (digit_count != '0) &&
                        (digit_count != CNT_W'(NUM_DIGITS)) && (index == '0);
`else
  assign cursor_blank = 1'b0;
`endif

  // Output registers follow the timer state by one cycle, so DEAD cycles are always dark.
  always_ff @(posedge clk) begin
    if (rst || !drive_active) begin
      seg    <= '0;
      dig_en <= '0;
    end else begin
      dig_en <= NUM_DIGITS'(1) << index;
      seg    <= (valid_mask[index] && !cursor_blank) ? hex_to_seg(digits[index]) : 7'd0;
    end
  end

  assign disp_value = digits;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl: stimulus pushes per-cycle expectations, a monitor pops and compares.
`timescale 1ns/1ps
module tb_ssd_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'h0;
  logic       clear = 1'b0;
  logic [6:0] seg;
  logic [1:0] dig_en;
  logic [7:0] disp_value;
  logic [1:0] digit_count;

  ssd_scan_ctrl #(
    .NUM_DIGITS  (2),
    .CLK_FREQ    (1000),
    .REFRESH_HZ  (50),
    .DEAD_CYCLES (2),
    .BLINK_DIV   (20)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .clear       (clear),
    .seg         (seg),
    .dig_en      (dig_en),
    .disp_value  (disp_value),
    .digit_count (digit_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic [1:0] dig_en;
    logic [7:0] disp;
    logic [1:0] cnt;
    bit         hchk;
    logic [7:0] hdisp;
    logic [1:0] hcnt;
  } exp_t;

  exp_t sb[$];
  int tests = 0;
  int fails = 0;

  logic [6:0] TBL [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  // Reference state: pos is the position within the 20-cycle frame after the last edge
  // (0..1 dead d0, 2..9 drive d0, 10..11 dead d1, 12..19 drive d1).
  logic [3:0] m_dig [2];
  logic [1:0] m_val;
  int         m_cnt;
  int         pos;
  int         bcnt;
  bit         bon;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
    end
  endtask

  task automatic step(input bit r, input bit kv, input logic [3:0] kc, input bit clr,
                      input bit hc = 1'b0, input logic [7:0] hd = 8'h00, input logic [1:0] hn = 2'd0);
    exp_t e;
    int   idx;
    bit   drv;
    bit   blank;
    @(negedge clk);
    rst = r; key_valid = kv; key_code = kc; clear = clr;
    e.hchk = hc; e.hdisp = hd; e.hcnt = hn;
    if (r) begin
      e.seg = 7'd0; e.dig_en = 2'b00;
      m_dig[0] = 4'h0; m_dig[1] = 4'h0; m_val = 2'b00; m_cnt = 0;
      pos = 0; bcnt = 0; bon = 1'b1;
    end else begin
      drv   = (pos % 10) >= 2;
      idx   = (pos / 10) % 2;
      blank = 1'b0;
`ifdef SSD_CURSOR_BLINK_EN
      blank = (idx == 0) && (m_cnt == 1) && !bon;
`endif
      e.dig_en = drv ? 2'(1 << idx) : 2'b00;
      e.seg    = (drv && m_val[idx] && !blank) ? TBL[m_dig[idx]] : 7'd0;
      if (clr) begin
        m_dig[0] = 4'h0; m_dig[1] = 4'h0; m_val = 2'b00; m_cnt = 0;
      end else if (kv) begin
        m_dig[1] = m_dig[0]; m_dig[0] = kc; m_val = {m_val[0], 1'b1};
        if (m_cnt < 2) m_cnt++;
      end
      pos = (pos + 1) % 20;
      if (bcnt == 19) begin bcnt = 0; bon = !bon; end
      else bcnt++;
    end
    e.disp = {m_dig[1], m_dig[0]};
    e.cnt  = 2'(m_cnt);
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 4'h0, 1'b0);
  endtask

  task automatic run_to(input int p);
    int guard = 0;
    while (pos != p && guard < 40) begin
      step(1'b0, 1'b0, 4'h0, 1'b0);
      guard++;
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("seg", 32'(seg), 32'(e.seg));
        check("dig_en", 32'(dig_en), 32'(e.dig_en));
        check("disp_value", 32'(disp_value), 32'(e.disp));
        check("digit_count", 32'(digit_count), 32'(e.cnt));
        check("dig_en_onehot0", 32'($onehot0(dig_en)), 32'd1);
        if (e.hchk) begin
          check("entry_disp", 32'(disp_value), 32'(e.hdisp));
          check("entry_count", 32'(digit_count), 32'(e.hcnt));
        end
      end
    end
  end

  initial begin : stimulus
    int guard;
    repeat (3) step(1'b1, 1'b0, 4'h0, 1'b0);
    // Idle scan with empty buffer
    idle(40);
    // Entry shift
    step(1'b0, 1'b1, 4'h1, 1'b0, 1'b1, 8'h01, 2'd1);
    step(1'b0, 1'b1, 4'hA, 1'b0, 1'b1, 8'h1A, 2'd2);
    idle(22);
    // Overflow: oldest digit drops off
    step(1'b0, 1'b1, 4'h5, 1'b0, 1'b1, 8'hA5, 2'd2);
    step(1'b0, 1'b1, 4'hF, 1'b0, 1'b1, 8'h5F, 2'd2);
    step(1'b0, 1'b1, 4'h3, 1'b0, 1'b1, 8'hF3, 2'd2);
    idle(20);
    // Clear wins over a simultaneous key
    step(1'b0, 1'b1, 4'h7, 1'b1, 1'b1, 8'h00, 2'd0);
    idle(20);
    // Mid-slot reset during digit 1 DRIVE cycle 5
    step(1'b0, 1'b1, 4'h2, 1'b0, 1'b1, 8'h02, 2'd1);
    step(1'b0, 1'b1, 4'h4, 1'b0, 1'b1, 8'h24, 2'd2);
    run_to(16);
    step(1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 8'h00, 2'd0);
    idle(25);
    // Single digit entered: cursor blink case
    step(1'b0, 1'b1, 4'h8, 1'b0, 1'b1, 8'h08, 2'd1);
    idle(85);
    // Drain the scoreboard with a bounded wait
    guard = 0;
    while (sb.size() > 0 && guard < 10) begin
      @(posedge clk);
      guard++;
    end
    #2;
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
Parametrised N-digit seven-segment display controller fed by the keypad decoder. It holds an entry buffer of NUM_DIGITS hex digits and shifts each new key in from the right. Digits not yet entered are blanked. The controller time-multiplexes the digits onto one shared segment bus, with a programmable refresh rate and a dead-time (anti-ghosting) gap between digits. It replaces the fixed two-digit chip-select toggling in the SSD top level.

Parameters:
- NUM_DIGITS, 2: number of multiplexed digits, 1..8.
- CLK_FREQ, 125_000_000: clk frequency in Hz.
- REFRESH_HZ, 1000: full-frame refresh rate. Per-digit slot is PERIOD = CLK_FREQ/(REFRESH_HZ*NUM_DIGITS) cycles.
- DEAD_CYCLES, 16: cycles at the start of each slot with all digit enables off. Elaboration error if PERIOD <= DEAD_CYCLES.
- BLINK_DIV, 62_500_000: half-period in cycles of the cursor blink. Used only with the optional feature.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- key_valid, input, 1: single-cycle pulse; key_code is valid in that cycle.
- key_code, input, 4: hex value of the pressed key.
- clear, input, 1: single-cycle pulse; empties the entry buffer.
- seg, output, 7: segments {g,f,e,d,c,b,a}, active-high, registered.
- dig_en, output, NUM_DIGITS: one-hot digit enable, active-high, registered.
- disp_value, output, 4*NUM_DIGITS: buffer contents; digit 0 is in the LSBs.
- digit_count, output, $clog2(NUM_DIGITS+1): number of valid entered digits, saturating at NUM_DIGITS.

Behaviour:
- Reset:
  - digits = 0, valid mask = 0, digit_count = 0.
  - seg = 0, dig_en = 0.
  - FSM = DEAD, scan index = 0, slot counter = 0.
- Entry buffer:
  - On key_valid, digit[i] <= digit[i-1] for i >= 1, and digit[0] <= key_code.
  - The valid mask shifts the same way with bit 0 set.
  - digit_count increments, saturating at NUM_DIGITS. The oldest digit falls off the top.
  - Update is visible on disp_value the next cycle.
- clear zeroes the digits, the valid mask and digit_count. If clear and key_valid arrive in the same cycle, clear wins and the key is dropped.
- Scan FSM:
  - States: DEAD and DRIVE.
  - DEAD lasts DEAD_CYCLES cycles: dig_en = 0, seg = 0.
  - DRIVE lasts PERIOD-DEAD_CYCLES cycles: dig_en = one-hot(index); seg = decode(digit[index]) if valid[index], else 0.
  - At the end of DRIVE, the index advances (NUM_DIGITS-1 wraps to 0) and the FSM returns to DEAD.
- Latency:
  - seg and dig_en are registered: they change one cycle after the FSM state/counter transition.
  - A key entered during DRIVE shows on seg 2 cycles after the key_valid cycle. The digit mask updates mid-slot; no waiting for the next slot.
- dig_en is never more than one-hot, and is all-zero in every DEAD cycle. These hold for every transition, including reset release.
- rst asserted mid-slot: outputs return to reset values in the next cycle. The scan restarts at index 0 in DEAD after rst deasserts.
- key_valid and clear are ignored while rst is high.
- Decode table:
  - 0→0111111, 1→0000110, 2→1011011, 3→1001111, 4→1100110, 5→1101101, 6→1111101, 7→0000111
  - 8→1111111, 9→1101111, A→1110111, B→1111100, C→0111001, D→1011110, E→1111001, F→1110001
- NUM_DIGITS = 1: the index stays 0, and DEAD/DRIVE still alternate.

Optional Feature:
- Macro: SSD_CURSOR_BLINK_EN.
- When defined:
  - A free-running blink counter toggles a blink phase every BLINK_DIV cycles. The counter and phase reset to 0 / phase on.
  - While digit_count < NUM_DIGITS and the phase is off, digit 0 outputs seg = 0 during its DRIVE slot. dig_en is unchanged.
  - When the buffer is full, or when digit_count = 0, there is no blinking.
- When not defined: no blink logic; BLINK_DIV is ignored. Behaviour is identical to the phase being permanently on.

Decomposition:
- Package ssd_pkg contains:
  - typedef enum logic {DEAD, DRIVE} scan_state_t.
  - A constant 16-entry seg pattern array (table above).
  - Function hex_to_seg(logic [3:0]) returning logic [6:0].
- Sub-module ssd_slot_timer generates the slot timing:
  - Parameters PERIOD and DEAD_CYCLES.
  - Outputs: drive_active, and slot_end as a 1-cycle pulse.
- ssd_scan_ctrl holds the buffer, the index, and the output registers.

Test Plan:
Bench uses CLK_FREQ=1000, REFRESH_HZ=50, NUM_DIGITS=2, DEAD_CYCLES=2, giving PERIOD=10.
- Reset scan: release rst, enter no keys. dig_en pattern per slot is 00×2 then 01×8, then 00×2 then 10×8, repeating. seg = 0 throughout; never two dig_en bits high.
- Entry shift: key_valid with 0x1, then 0xA. disp_value = 0x01, then 0x1A; digit_count = 1, then 2. Digit 0 shows 1110111; digit 1 shows 0000110.
- Overflow: keys 0x5, 0xF, 0x3. disp_value = 0xF3, digit_count stays 2, and 0x5 is discarded.
- Clear collision: clear and key_valid(0x7) in the same cycle. disp_value = 0, digit_count = 0, seg = 0 in all DRIVE cycles.
- Mid-slot reset: assert rst in DRIVE cycle 5 of digit 1. Next cycle seg = 0, dig_en = 0, digit_count = 0. After release the first DRIVE is on digit 0.
- Blink: with SSD_CURSOR_BLINK_EN, BLINK_DIV=20, and key 0x8 entered, digit 0 seg alternates between 1111111 and 0 every 20 cycles. With the macro undefined, it stays at 1111111.
